scratchpad_pkt_mem: RTL and testbench



---
 rtl/scratchpad_pkt_mem.sv | 255 +++++++++++++++++++++++++
 tb/tb_scratchpad_pkt_mem.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_pkt_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : scratchpad_pkt_mem
//  Brief    : NoC-packet-driven single-port scratchpad. Consumes write/read
//             request packets, returns read-response and optional write-ack
//             packets, and counts malformed requests.
//  Revision : 1.0 - initial release
// ============================================================================
module scratchpad_pkt_mem #(
    parameter int BW        = 32,
    parameter int BWB       = BW/8,
    parameter int XY_SZ     = 3,
    parameter int DEPTH     = 1024,
    parameter int LEN_W     = 8,
    parameter int WRITE_ACK = 0
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_high,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 stream_in_TVALID,
    input  logic [BW-1:0]        stream_in_TDATA,
    input  logic [BWB-1:0]       stream_in_TKEEP,
    input  logic                 stream_in_TLAST,
    output logic                 stream_in_TREADY,
    output logic                 stream_out_TVALID,
    output logic [BW-1:0]        stream_out_TDATA,
    output logic [BWB-1:0]       stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    input  logic                 stream_out_TREADY,
    output logic [15:0]          err_count,
    output logic                 busy
);
    localparam int         c_ADDR_W   = $clog2(DEPTH);
    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR1  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_READ  = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;

    // Request context
    logic [2*XY_SZ-1:0]    r_src;
    logic [LEN_W-1:0]      r_len;
    logic [1:0]            r_op;
    logic [c_ADDR_W-1:0]   r_start;
    logic [c_ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_phase;      // response header word already queued
    logic                  r_rd_done;    // all data reads issued
    logic [15:0]           r_err;

    // RAM and read pipeline
    logic [BW-1:0]         r_mem [DEPTH];
    logic [BW-1:0]         r_rd_data;
    logic                  r_pend;       // a RAM read lands this cycle
    logic                  r_pend_last;

    // Two-entry output FIFO
    logic [BW-1:0]         r_fd [2];
    logic                  r_fl [2];
    logic                  r_wp, r_rp;
    logic [1:0]            r_fcount;

    // Combinational controls
    logic                  w_ready, w_in_hs, w_pop, w_last_cnt, w_fifo_room;
    logic                  w_err_inc, w_mem_we, w_issue;
    logic                  w_hdr_push, w_hdr_last;
    logic [BW-1:0]         w_hdr_data;
    logic [2:0]            w_occ;
    logic                  w_push, w_push_last;
    logic [BW-1:0]         w_push_data;
    logic [BW-1:0]         w_word_rd, w_word_ack, w_word1;
    logic                  w_unused;

    // TKEEP and unused header bits carry no meaning here
    assign w_unused    = &{1'b0, stream_in_TKEEP, stream_in_TDATA};

    assign w_in_hs     = stream_in_TVALID & stream_in_TREADY;
    assign w_pop       = stream_out_TVALID & stream_out_TREADY;
    assign w_last_cnt  = (r_cnt == (r_len - LEN_W'(1)));
    assign w_fifo_room = (r_fcount != 2'd2) | w_pop;
    assign w_word1     = BW'(r_start);

    // Response header words built from the latched request
    always_comb begin
        w_word_rd = '0;
        w_word_rd[BW-1:BW-2]           = 2'b10;
        w_word_rd[BW-3 -: LEN_W]       = r_len;
        w_word_rd[4*XY_SZ-1:2*XY_SZ]   = HsrcId;
        w_word_rd[2*XY_SZ-1:0]         = r_src;
        w_word_ack                     = w_word_rd;
        w_word_ack[BW-1:BW-2]          = 2'b11;
        w_word_ack[BW-3 -: LEN_W]      = '0;
    end

    // State register
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) r_state <= S_IDLE;
        else                   r_state <= w_state_nxt;
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_err_inc   = 1'b0;
        w_mem_we    = 1'b0;
        w_issue     = 1'b0;
        w_hdr_push  = 1'b0;
        w_hdr_last  = 1'b0;
        w_hdr_data  = '0;
        w_occ       = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_in_hs) w_state_nxt = S_HDR1;
            end
            S_HDR1: begin
                w_ready = 1'b1;
                if (w_in_hs) begin
                    if (r_op == c_OP_WRITE && r_len != '0 && !stream_in_TLAST) begin
                        w_state_nxt = S_WRITE;
                    end else if (r_op == c_OP_READ && r_len != '0 && stream_in_TLAST) begin
                        w_state_nxt = S_READ;
                        w_hdr_push  = 1'b1;
                        w_hdr_data  = w_word_rd;
                    end else begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = stream_in_TLAST ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_WRITE: begin
                w_ready = 1'b1;
                if (w_in_hs) begin
                    w_mem_we = 1'b1;
                    if (stream_in_TLAST) begin
                        w_err_inc   = !w_last_cnt;
                        w_state_nxt = (WRITE_ACK != 0) ? S_ACK : S_IDLE;
                    end else if (w_last_cnt) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_ready = 1'b1;
                if (w_in_hs && stream_in_TLAST) w_state_nxt = S_IDLE;
            end
            S_READ: begin
                if (!r_phase && w_fifo_room) begin
                    w_hdr_push = 1'b1;
                    w_hdr_data = w_word1;
                end
                // Slots committed after this cycle, including the read in flight
                w_occ = {1'b0, r_fcount} + {2'b00, w_hdr_push} + {2'b00, r_pend} - {2'b00, w_pop};
                if ((r_phase || w_hdr_push) && !r_rd_done && (w_occ <= 3'd1)) w_issue = 1'b1;
                if (w_pop && stream_out_TLAST) w_state_nxt = S_IDLE;
            end
            S_ACK: begin
                if (!r_phase && w_fifo_room) begin
                    w_hdr_push = 1'b1;
                    w_hdr_data = w_word_ack;
                    w_hdr_last = 1'b1;
                end
                if (w_pop && stream_out_TLAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A landing RAM word and a header word never compete for the same cycle
    assign w_push      = w_hdr_push | r_pend;
    assign w_push_data = r_pend ? r_rd_data : w_hdr_data;
    assign w_push_last = r_pend ? r_pend_last : w_hdr_last;

    // RAM: write port driven by WRITE beats, registered read port for responses
    always_ff @(posedge clk_line) begin
        if (w_mem_we) r_mem[r_addr] <= stream_in_TDATA;
        if (w_issue)  r_rd_data     <= r_mem[r_addr];
    end

    // Request context, counters, read pipeline and output FIFO
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            r_src       <= '0;
            r_len       <= '0;
            r_op        <= '0;
            r_start     <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_rd_done   <= 1'b0;
            r_err       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_fd[0]     <= '0;
            r_fd[1]     <= '0;
            r_fl[0]     <= 1'b0;
            r_fl[1]     <= 1'b0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_fcount    <= '0;
        end else begin
            if (r_state == S_IDLE && w_in_hs) begin
                r_src <= stream_in_TDATA[4*XY_SZ-1:2*XY_SZ];
                r_len <= stream_in_TDATA[BW-3 -: LEN_W];
                r_op  <= stream_in_TDATA[BW-1:BW-2];
            end
            if (r_state == S_HDR1 && w_in_hs) begin
                r_start   <= stream_in_TDATA[c_ADDR_W-1:0];
                r_addr    <= stream_in_TDATA[c_ADDR_W-1:0];
                r_cnt     <= '0;
                r_phase   <= 1'b0;
                r_rd_done <= 1'b0;
            end
            if (w_mem_we || w_issue) begin
                r_addr <= r_addr + c_ADDR_W'(1);
                r_cnt  <= r_cnt + LEN_W'(1);
            end
            if (w_issue) begin
                r_pend_last <= w_last_cnt;
                if (w_last_cnt) r_rd_done <= 1'b1;
            end
            r_pend <= w_issue;
            if ((r_state == S_READ || r_state == S_ACK) && w_hdr_push) r_phase <= 1'b1;
            if (w_err_inc && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (w_push) begin
                r_fd[r_wp] <= w_push_data;
                r_fl[r_wp] <= w_push_last;
                r_wp       <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_fcount <= r_fcount + 2'(w_push) - 2'(w_pop);
        end
    end

    assign stream_in_TREADY  = w_ready & ~clk_line_rst_high;
    assign stream_out_TVALID = (r_fcount != 2'd0);
    assign stream_out_TDATA  = r_fd[r_rp];
    assign stream_out_TLAST  = r_fl[r_rp];
    assign stream_out_TKEEP  = '1;
    assign err_count         = r_err;
    assign busy              = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_pkt_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_scratchpad_pkt_mem
//  Brief    : Directed bench for scratchpad_pkt_mem (WRITE_ACK=0 instance plus
//             a WRITE_ACK=1 instance for the acknowledge scenario).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scratchpad_pkt_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  own_id = 6'b011_101;   // {Y=3, X=5}
    logic        sel;                   // 0: main instance, 1: ack instance
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_keep;
    logic [15:0] a_err;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_keep;
    logic [15:0] b_err;

    logic        cur_in_ready, cur_out_valid, cur_out_last;
    logic [31:0] cur_out_data;

    assign a_in_valid    = in_valid & ~sel;
    assign b_in_valid    = in_valid &  sel;
    assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign cur_out_valid = sel ? b_out_valid : a_out_valid;
    assign cur_out_data  = sel ? b_out_data  : a_out_data;
    assign cur_out_last  = sel ? b_out_last  : a_out_last;

    scratchpad_pkt_mem #(.WRITE_ACK(0)) dut (
        .clk_line(clk), .clk_line_rst_high(rst), .HsrcId(own_id),
        .stream_in_TVALID(a_in_valid), .stream_in_TDATA(in_data), .stream_in_TKEEP(4'h0),
        .stream_in_TLAST(in_last), .stream_in_TREADY(a_in_ready),
        .stream_out_TVALID(a_out_valid), .stream_out_TDATA(a_out_data), .stream_out_TKEEP(a_out_keep),
        .stream_out_TLAST(a_out_last), .stream_out_TREADY(out_ready),
        .err_count(a_err), .busy(a_busy));

    scratchpad_pkt_mem #(.WRITE_ACK(1)) dut_ack (
        .clk_line(clk), .clk_line_rst_high(rst), .HsrcId(own_id),
        .stream_in_TVALID(b_in_valid), .stream_in_TDATA(in_data), .stream_in_TKEEP(4'h0),
        .stream_in_TLAST(in_last), .stream_in_TREADY(b_in_ready),
        .stream_out_TVALID(b_out_valid), .stream_out_TDATA(b_out_data), .stream_out_TKEEP(b_out_keep),
        .stream_out_TLAST(b_out_last), .stream_out_TREADY(out_ready),
        .err_count(b_err), .busy(b_busy));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] tx_q [$];
    logic [31:0] rx_d [$];
    logic        rx_l [$];
    int          rx_t [$];
    logic [31:0] exp_q [$];

    // Request header: src (Y=1,X=2), dst (Y=3,X=5)
    function automatic logic [31:0] req_hdr(input logic [1:0] op, input logic [7:0] len);
        return {op, len, 10'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    endfunction
    // Response header: src = own tile (3,5), dst = requester (1,2)
    function automatic logic [31:0] resp_hdr(input logic [1:0] op, input logic [7:0] len);
        return {op, len, 10'd0, 3'd3, 3'd5, 3'd1, 3'd2};
    endfunction

    // Present one beat at a negedge and return at the negedge after its handshake
    task automatic send_word(input logic [31:0] d, input logic l);
        int t;
        in_valid = 1'b1; in_data = d; in_last = l; t = 0;
        while (cur_in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: word %h never accepted", d);
        end
        @(negedge clk);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < tx_q.size(); i++) send_word(tx_q[i], i == tx_q.size() - 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Collect one response packet; mode 1 applies back-pressure
    task automatic recv(input int mode);
        logic pv, pr, pl;
        logic [31:0] pd;
        int cyc;
        bit done;
        rx_d.delete(); rx_l.delete(); rx_t.delete();
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; done = 1'b0; cyc = 0;
        while (!done && cyc < 400) begin
            if (mode == 0)     out_ready = 1'b1;
            else if (cyc < 8)  out_ready = (cyc % 2 == 0);
            else               out_ready = ($urandom_range(0, 2) != 0);
            if (pv && !pr) begin
                n_assert++;
                if (!(cur_out_valid === 1'b1 && cur_out_data === pd && cur_out_last === pl)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, held d=%h l=%b",
                             cur_out_valid, cur_out_data, cur_out_last, pd, pl);
                end
            end
            if (cur_out_valid === 1'b1 && out_ready) begin
                rx_d.push_back(cur_out_data); rx_l.push_back(cur_out_last); rx_t.push_back(cyc);
                if (cur_out_last === 1'b1) done = 1'b1;
            end
            pv = cur_out_valid; pr = out_ready; pd = cur_out_data; pl = cur_out_last;
            @(negedge clk); cyc++;
        end
        out_ready = 1'b1;
        if (!done) begin
            n_assert++; n_fail++;
            $display("FAIL recv_timeout: %0d beats, no TLAST", rx_d.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_assert++; if (a_in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
        n_assert++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        n_assert++; if (a_out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_out_last: got %b want 0", a_out_last); end
        n_assert++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", a_out_data); end
        n_assert++; if (a_err !== 16'h0)      begin n_fail++; $display("FAIL rst_err: got %h want 0", a_err); end
        n_assert++; if (a_busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_assert++; if (a_out_keep !== 4'hF)  begin n_fail++; $display("FAIL rst_keep: got %h want f", a_out_keep); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (a_in_ready !== 1'b1)  begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_write_read(input logic [31:0] addr);
        logic [31:0] got;
        logic        gl;
        tx_q = {req_hdr(2'b00, 8'd4), addr, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
        send_pkt();
        tx_q = {req_hdr(2'b01, 8'd4), addr};
        send_pkt();
        recv(0);
        exp_q = {32'h8100_074A, addr, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
        n_assert++;
        if (rx_d.size() != 6) begin n_fail++; $display("FAIL wr_rd_beats: got %0d want 6", rx_d.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_d.size()) ? rx_d[i] : 32'hxxxx_xxxx;
            gl  = (i < rx_l.size()) ? rx_l[i] : 1'bx;
            n_assert++;
            if (got !== exp_q[i] || gl !== (i == 5)) begin
                n_fail++; $display("FAIL wr_rd_beat%0d: got %h/%b want %h/%b", i, got, gl, exp_q[i], i == 5);
            end
        end
        n_assert++;
        if (rx_t.size() < 3 || rx_t[0] != 0 || rx_t[2] > 2) begin
            n_fail++; $display("FAIL rd_latency: word0 at +%0d, data0 at +%0d, want +0 and <=+2",
                               rx_t.size() > 0 ? rx_t[0] : -1, rx_t.size() > 2 ? rx_t[2] : -1);
        end
        n_assert++; if (a_err !== 16'd0) begin n_fail++; $display("FAIL wr_rd_err: got %0d want 0", a_err); end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        tx_q = {req_hdr(2'b00, 8'd3), 32'h3FF, 32'd1, 32'd2, 32'd3};
        send_pkt();
        tx_q = {req_hdr(2'b01, 8'd3), 32'h3FF};
        send_pkt();
        recv(0);
        exp_q = {resp_hdr(2'b10, 8'd3), 32'h3FF, 32'd1, 32'd2, 32'd3};
        n_assert++;
        if (rx_d.size() != 5) begin n_fail++; $display("FAIL wrap_beats: got %0d want 5", rx_d.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rx_d.size()) ? rx_d[i] : 32'hxxxx_xxxx;
            n_assert++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL wrap_beat%0d: got %h want %h", i, got, exp_q[i]); end
        end
        tx_q = {req_hdr(2'b01, 8'd1), 32'h000};
        send_pkt();
        recv(0);
        got = (rx_d.size() > 2) ? rx_d[2] : 32'hxxxx_xxxx;
        n_assert++; if (got !== 32'd2) begin n_fail++; $display("FAIL wrap_addr0: got %h want 2", got); end
    endtask

    task automatic test_stall();
        logic [31:0] got;
        logic        gl;
        tx_q = {req_hdr(2'b00, 8'd16), 32'h040};
        for (int i = 0; i < 16; i++) tx_q.push_back(32'h1000 + i);
        send_pkt();
        tx_q = {req_hdr(2'b01, 8'd16), 32'h040};
        send_pkt();
        recv(1);
        exp_q = {resp_hdr(2'b10, 8'd16), 32'h040};
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + i);
        n_assert++;
        if (rx_d.size() != 18) begin n_fail++; $display("FAIL stall_beats: got %0d want 18", rx_d.size()); end
        for (int i = 0; i < 18; i++) begin
            got = (i < rx_d.size()) ? rx_d[i] : 32'hxxxx_xxxx;
            gl  = (i < rx_l.size()) ? rx_l[i] : 1'bx;
            n_assert++;
            if (got !== exp_q[i] || gl !== (i == 17)) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, got, gl, exp_q[i], i == 17);
            end
        end
    endtask

    task automatic test_write_ack();
        logic seen;
        tx_q = {req_hdr(2'b00, 8'd2), 32'h080, 32'h11, 32'h22};
        send_pkt();
        seen = 1'b0;
        repeat (8) begin seen = seen | a_out_valid; @(negedge clk); end
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL noack_beat: got valid=%b want 0", seen); end
        sel = 1'b1;
        send_pkt();
        recv(0);
        n_assert++;
        if (rx_d.size() != 1 || rx_d[0] !== 32'hC000_074A || rx_l[0] !== 1'b1) begin
            n_fail++; $display("FAIL ack_word: got %0d beats first %h, want 1 beat c000074a last",
                               rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 32'hx);
        end
        n_assert++; if (b_busy !== 1'b0 || b_out_keep !== 4'hF) begin n_fail++; $display("FAIL ack_idle: got busy=%b keep=%h want 0/f", b_busy, b_out_keep); end
        sel = 1'b0;
    endtask

    task automatic test_malformed();
        logic [31:0] got;
        tx_q = {req_hdr(2'b00, 8'd4), 32'h100, 32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003};
        send_pkt();
        tx_q = {req_hdr(2'b00, 8'd4), 32'h200, 32'h6600_0000, 32'h6600_0001, 32'h6600_0002, 32'h6600_0003};
        send_pkt();
        tx_q = {req_hdr(2'b11, 8'd3), 32'h0, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
        send_pkt();
        @(negedge clk);
        n_assert++; if (a_err !== 16'd1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL bad_op: got err=%0d busy=%b want 1/0", a_err, a_busy); end
        tx_q = {req_hdr(2'b00, 8'd4), 32'h100, 32'hB0, 32'hB1};
        send_pkt();
        @(negedge clk);
        n_assert++; if (a_err !== 16'd2 || a_busy !== 1'b0) begin n_fail++; $display("FAIL short_wr: got err=%0d busy=%b want 2/0", a_err, a_busy); end
        tx_q = {req_hdr(2'b01, 8'd4), 32'h100};
        send_pkt();
        recv(0);
        exp_q = {resp_hdr(2'b10, 8'd4), 32'h100, 32'hB0, 32'hB1, 32'h5500_0002, 32'h5500_0003};
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_d.size()) ? rx_d[i] : 32'hxxxx_xxxx;
            n_assert++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL short_wr_beat%0d: got %h want %h", i, got, exp_q[i]); end
        end
        tx_q = {req_hdr(2'b00, 8'd2), 32'h200, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
        send_pkt();
        @(negedge clk);
        n_assert++; if (a_err !== 16'd3 || a_busy !== 1'b0) begin n_fail++; $display("FAIL long_wr: got err=%0d busy=%b want 3/0", a_err, a_busy); end
        tx_q = {req_hdr(2'b01, 8'd4), 32'h200};
        send_pkt();
        recv(0);
        exp_q = {resp_hdr(2'b10, 8'd4), 32'h200, 32'hC0, 32'hC1, 32'h6600_0002, 32'h6600_0003};
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_d.size()) ? rx_d[i] : 32'hxxxx_xxxx;
            n_assert++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL long_wr_beat%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_read();
        int beats, t;
        tx_q = {req_hdr(2'b01, 8'd8), 32'h040};
        send_pkt();
        beats = 0; t = 0;
        while (beats < 4 && t < 100) begin
            if (a_out_valid === 1'b1) beats++;
            @(negedge clk); t++;
        end
        n_assert++; if (beats != 4 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rd_reach: got %0d beats valid=%b want 4/1", beats, a_out_valid); end
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rd_reset: got valid=%b busy=%b want 0/0", a_out_valid, a_busy); end
        rst = 1'b0;
        @(negedge clk);
        test_write_read(32'h020);
        tx_q = {req_hdr(2'b01, 8'd1), 32'h010};
        send_pkt();
        recv(0);
        n_assert++;
        if (rx_d.size() != 3 || rx_d[2] !== 32'hA0) begin
            n_fail++; $display("FAIL ram_kept: got %0d beats data %h want 3/a0", rx_d.size(), rx_d.size() > 2 ? rx_d[2] : 32'hx);
        end
    endtask

    initial begin
        sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_write_read(32'h010);
        test_wrap();
        test_stall();
        test_write_ack();
        test_malformed();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
